// File: rtl/data_memory_router_pkg.sv
// data_memory_router_pkg
//   Shared types for the LSU-to-memory router: store width encoding, the
//   response bundle returned to the LSUs, and the address-window decoder
//   used by the top level for both the load and store directions.
package data_memory_router_pkg;

  // Decoder is sized for up to MAX_PORTS windows. Routers are instantiated
  // with N_PORTS <= MAX_PORTS, and the unused entries are masked out.
  localparam int unsigned MAX_PORTS = 16;
  localparam int unsigned IDX_W     = $clog2(MAX_PORTS);

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } store_width_t;

  // Response driven back to an LSU.
  typedef struct packed {
    logic        valid;
    logic        error;
    logic [31:0] data;
  } rtr_rsp_t;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] index;
  } region_dec_t;

  // Inclusive window match. The first matching index wins, so overlapping
  // windows resolve to the lowest port.
  function automatic region_dec_t region_decode(
    input logic [31:0]                 addr,
    input logic [MAX_PORTS-1:0][31:0]  base,
    input logic [MAX_PORTS-1:0][31:0]  lim,
    input int unsigned                 n_ports
  );
    region_dec_t r;
    r = '0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      if (!r.hit && (i < n_ports) && (addr >= base[i]) && (addr <= lim[i])) begin
        r.hit   = 1'b1;
        r.index = IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/data_memory_router_if.sv
// data_memory_router_if
//   Bundles the LSU-facing and memory-port-facing signals of the router.
//   Signal suffixes are relative to the router: _i is driven into it and
//   _o is driven by it.
//   slave  : router side
//   master : environment side (LSUs plus downstream memory ports)
interface data_memory_router_if #(
  parameter int unsigned N_PORTS = 2
) ();
  import data_memory_router_pkg::*;

  // load unit
  logic                      ldu_request_i;
  logic [31:0]               ldu_address_i;
  logic                      ldu_invalidate_i;
  logic                      ldu_ready_o;
  logic                      ldu_valid_o;
  logic [31:0]               ldu_data_o;
  logic                      ldu_error_o;
  // store unit
  logic                      stu_request_i;
  logic [31:0]               stu_address_i;
  logic [31:0]               stu_data_i;
  store_width_t              stu_width_i;
  logic                      stu_ready_o;
  logic                      stu_done_o;
  logic                      stu_error_o;
  // downstream load ports
  logic [N_PORTS-1:0]        port_load_request_o;
  logic [31:0]               port_load_address_o;
  logic                      port_load_invalidate_o;
  logic [N_PORTS-1:0]        port_load_valid_i;
  logic [N_PORTS-1:0][31:0]  port_load_data_i;
  // downstream store ports
  logic [N_PORTS-1:0]        port_store_request_o;
  logic [31:0]               port_store_address_o;
  logic [31:0]               port_store_data_o;
  store_width_t              port_store_width_o;
  logic [N_PORTS-1:0]        port_store_done_i;

  modport slave (
    input  ldu_request_i, ldu_address_i, ldu_invalidate_i,
    output ldu_ready_o, ldu_valid_o, ldu_data_o, ldu_error_o,
    input  stu_request_i, stu_address_i, stu_data_i, stu_width_i,
    output stu_ready_o, stu_done_o, stu_error_o,
    output port_load_request_o, port_load_address_o, port_load_invalidate_o,
    input  port_load_valid_i, port_load_data_i,
    output port_store_request_o, port_store_address_o, port_store_data_o,
    output port_store_width_o,
    input  port_store_done_i
  );

  modport master (
    output ldu_request_i, ldu_address_i, ldu_invalidate_i,
    input  ldu_ready_o, ldu_valid_o, ldu_data_o, ldu_error_o,
    output stu_request_i, stu_address_i, stu_data_i, stu_width_i,
    input  stu_ready_o, stu_done_o, stu_error_o,
    input  port_load_request_o, port_load_address_o, port_load_invalidate_o,
    output port_load_valid_i, port_load_data_i,
    input  port_store_request_o, port_store_address_o, port_store_data_o,
    input  port_store_width_o,
    output port_store_done_i
  );

endinterface

// File: rtl/data_memory_router_route_tracker.sv
// route_tracker
//   In-flight bookkeeping for one direction (load or store). All in-flight
//   requests target a single port (cur_port), so responses come back in
//   order from that port alone and need no tags.
//   clk_i, rst_n_i : clock, async active-low reset
//   req_i          : LSU request
//   hit_i, port_i  : decoded window hit and port index for the request
//   rsp_i          : per-port response strobes (valid / done)
//   ready_o        : request can be accepted this cycle
//   acc_map_o      : accepted toward a mapped port (drives the strobe)
//   rsp_fwd_o      : response from cur_port forwarded this cycle
//   err_o          : error response for an unmapped request this cycle
//   cur_port_o     : port targeted by in-flight requests
module route_tracker
  import data_memory_router_pkg::*;
#(
  parameter int unsigned N_PORTS         = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               req_i,
  input  logic               hit_i,
  input  logic [IDX_W-1:0]   port_i,
  input  logic [N_PORTS-1:0] rsp_i,
  output logic               ready_o,
  output logic               acc_map_o,
  output logic               rsp_fwd_o,
  output logic               err_o,
  output logic [IDX_W-1:0]   cur_port_o
);

  localparam int unsigned   CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  logic [CW-1:0]    count_q, count_d;
  logic [IDX_W-1:0] cur_port_q, cur_port_d;
  logic             err_q, err_d;
  logic             idle, acc, rsp_sel;

  assign idle = (count_q == '0);

  // A new port (or an unmapped address) is only taken once the current
  // port has drained, which keeps responses in order without tagging.
  assign ready_o   = (count_q < CNT_MAX) && !err_q &&
                     (idle || (hit_i && (port_i == cur_port_q)));
  assign acc       = req_i & ready_o;
  assign acc_map_o = acc & hit_i;

  always_comb begin
    rsp_sel = 1'b0;
    for (int unsigned p = 0; p < N_PORTS; p++)
      if (cur_port_q == IDX_W'(p)) rsp_sel = rsp_i[p];
  end

  // Responses with nothing outstanding (e.g. stragglers after reset) drop.
  assign rsp_fwd_o  = !idle && rsp_sel;
  assign err_o      = err_q;
  assign cur_port_o = cur_port_q;

  always_comb begin
    count_d    = count_q + CW'(acc_map_o) - CW'(rsp_fwd_o);
    cur_port_d = acc_map_o ? port_i : cur_port_q;
    // One-cycle pulse: ready is low while err_q is set, so no new
    // unmapped accept can overlap it.
    err_d      = acc & !hit_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q    <= '0;
      cur_port_q <= '0;
      err_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      cur_port_q <= cur_port_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: rtl/data_memory_router.sv
// data_memory_router
//   Routes LSU loads and stores to N_PORTS downstream memory ports by
//   address window, with up to MAX_OUTSTANDING in-flight requests per
//   direction to a single port. Unmapped addresses get a one-cycle-later
//   error response and never reach a port.
//   clk_i, rst_n_i : clock, async active-low reset
//   bus            : LSU and memory-port signals (slave modport)
//   REGION_BASE / REGION_END : packed N_PORTS x 32 inclusive windows,
//   port i in bits [32*i +: 32]. N_PORTS must lie in 2..MAX_PORTS.
module data_memory_router
  import data_memory_router_pkg::*;
#(
  parameter int unsigned              N_PORTS         = 2,
  parameter int unsigned              MAX_OUTSTANDING = 4,
  parameter logic [N_PORTS*32-1:0]    REGION_BASE     = {N_PORTS{32'h0}},
  parameter logic [N_PORTS*32-1:0]    REGION_END      = {N_PORTS{32'hFFFF_FFFF}}
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  data_memory_router_if.slave     bus
);

  // Windows widened to the decoder's fixed size; the extra entries are
  // excluded by the n_ports argument.
  localparam int unsigned EXT_W = MAX_PORTS * 32;
  localparam logic [MAX_PORTS-1:0][31:0] BASE_EXT = EXT_W'(REGION_BASE);
  localparam logic [MAX_PORTS-1:0][31:0] END_EXT  = EXT_W'(REGION_END);

  region_dec_t      ld_dec, st_dec;
  logic             ld_ready, ld_acc_map, ld_fwd, ld_err;
  logic             st_ready, st_acc_map, st_fwd, st_err;
  logic [IDX_W-1:0] ld_cur, st_cur;
  logic [31:0]      ld_sel_data;
  rtr_rsp_t         ld_rsp;

  assign ld_dec = region_decode(bus.ldu_address_i, BASE_EXT, END_EXT, N_PORTS);
  assign st_dec = region_decode(bus.stu_address_i, BASE_EXT, END_EXT, N_PORTS);

  route_tracker #(
    .N_PORTS         (N_PORTS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_ld_trk (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .req_i      (bus.ldu_request_i),
    .hit_i      (ld_dec.hit),
    .port_i     (ld_dec.index),
    .rsp_i      (bus.port_load_valid_i),
    .ready_o    (ld_ready),
    .acc_map_o  (ld_acc_map),
    .rsp_fwd_o  (ld_fwd),
    .err_o      (ld_err),
    .cur_port_o (ld_cur)
  );

  route_tracker #(
    .N_PORTS         (N_PORTS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_st_trk (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .req_i      (bus.stu_request_i),
    .hit_i      (st_dec.hit),
    .port_i     (st_dec.index),
    .rsp_i      (bus.port_store_done_i),
    .ready_o    (st_ready),
    .acc_map_o  (st_acc_map),
    .rsp_fwd_o  (st_fwd),
    .err_o      (st_err),
    .cur_port_o (st_cur)
  );

  // One-hot request strobes, combinational from the accept.
  for (genvar g = 0; g < N_PORTS; g++) begin : g_strobe
    assign bus.port_load_request_o[g]  = ld_acc_map && (ld_dec.index == IDX_W'(g));
    assign bus.port_store_request_o[g] = st_acc_map && (st_dec.index == IDX_W'(g));
  end

  // Shared request fields pass straight through to every port.
  assign bus.port_load_address_o    = bus.ldu_address_i;
  assign bus.port_load_invalidate_o = bus.ldu_invalidate_i;
  assign bus.port_store_address_o   = bus.stu_address_i;
  assign bus.port_store_data_o      = bus.stu_data_i;
  assign bus.port_store_width_o     = bus.stu_width_i;

  assign bus.ldu_ready_o = ld_ready;
  assign bus.stu_ready_o = st_ready;

  // Load data mux keyed by the registered cur_port.
  always_comb begin
    ld_sel_data = '0;
    for (int unsigned p = 0; p < N_PORTS; p++)
      if (ld_cur == IDX_W'(p)) ld_sel_data = bus.port_load_data_i[p];
  end

  // Data is zero when idle and on error responses.
  always_comb begin
    ld_rsp       = '0;
    ld_rsp.valid = ld_fwd | ld_err;
    ld_rsp.error = ld_err;
    if (ld_fwd) ld_rsp.data = ld_sel_data;
  end

  assign bus.ldu_valid_o = ld_rsp.valid;
  assign bus.ldu_error_o = ld_rsp.error;
  assign bus.ldu_data_o  = ld_rsp.data;

  assign bus.stu_done_o  = st_fwd | st_err;
  assign bus.stu_error_o = st_err;

endmodule

// File: doc/data_memory_router.md
# data_memory_router

Parametrised request router between the CPU load/store units and N downstream memory ports, for example the cached DDR path and one or more I/O regions. It decodes each request against per-port address windows and forwards it. It tracks up to MAX_OUTSTANDING in-flight requests per direction, so it can pipeline back-to-back accesses to the same port, and steers responses back in order. Unmapped addresses get an error response without a downstream access.

## Interface
Parameters:
- N_PORTS, 2: number of downstream load/store port pairs (≥2).
- MAX_OUTSTANDING, 4: in-flight requests per direction (power of two, ≥1).
- REGION_BASE, {N_PORTS{32'h0}}: packed N_PORTS×32 inclusive start address per port.
- REGION_END, {N_PORTS{32'hFFFF_FFFF}}: packed N_PORTS×32 inclusive end address per port.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- ldu_request_i / ldu_address_i / ldu_invalidate_i  in  1/32/1  load request.
- ldu_ready_o  out  1  router accepts a load this cycle.
- ldu_valid_o / ldu_data_o / ldu_error_o  out  1/32/1  load response.
- stu_request_i / stu_address_i / stu_data_i / stu_width_i  in  1/32/32/2  store request; width is store_width_t.
- stu_ready_o  out  1  router accepts a store this cycle.
- stu_done_o / stu_error_o  out  1/1  store response.
- port_load_request_o  out  N_PORTS  one-hot load strobe.
- port_load_address_o / port_load_invalidate_o  out  32/1  shared by all ports.
- port_load_valid_i / port_load_data_i  in  N_PORTS / N_PORTS×32  per-port load response.
- port_store_request_o  out  N_PORTS  one-hot store strobe.
- port_store_address_o / port_store_data_o / port_store_width_o  out  32/32/2  shared by all ports.
- port_store_done_i  in  N_PORTS  per-port store completion.

## Operation
- Decode: a port hits when REGION_BASE[i] ≤ addr ≤ REGION_END[i]. On overlapping windows the lowest index wins. No hit means unmapped.
- Each direction has one route tracker holding:
  - count, range 0..MAX_OUTSTANDING;
  - cur_port, the target of all in-flight requests;
  - err_pending.
- A request is accepted when request & ready. Ready is true iff all of:
  - count < MAX_OUTSTANDING;
  - !err_pending;
  - count == 0, or the decoded port == cur_port and the address is mapped.
- Accept to a mapped port:
  - assert port_*_request_o[port] for that cycle;
  - set cur_port, increment count.
- Accept to an unmapped address (only possible when count == 0):
  - no downstream strobe;
  - set err_pending.
- Response handling:
  - port_*_valid_i/done_i[cur_port] with count > 0: forward to the LSU and decrement count.
  - A response from a port ≠ cur_port, or any response with count == 0, is dropped.
  - Accept and response in the same cycle leave count unchanged.
- Error: when err_pending is set, the next cycle drives valid/done = 1, error = 1 and data = 0, then clears err_pending.
- Invalidate: ldu_invalidate_i is broadcast to every port's invalidate, independent of ready.
- Stores and loads are tracked independently; there is no load/store ordering across ports.

## Timing
- Downstream request strobes are combinational from the LSU request in the same cycle. Address, data and width pass through combinationally.
- The response path is a combinational mux selected by the registered cur_port. It adds zero cycles.
- Error response latency is exactly 1 cycle after accept.
- Port switch: a request to a new port is held (ready = 0) until count reaches 0. It is accepted in the cycle count reads 0, so the minimum turnaround is the cycle after the last response.
- Full: at count == MAX_OUTSTANDING, ready = 0. A response in that cycle frees a slot from the next cycle.
- Reset values:
  - count = 0, cur_port = 0, err_pending = 0;
  - all outputs 0, except ready = 1.
- Reset mid-operation clears all trackers. Late downstream responses after reset are dropped because count == 0.

## Structure
- Shared package holds store_width_t (BYTE, HALF, WORD), the router response type, and a decode helper function `region_decode(addr, base, end) -> {hit, index}`.
- Sub-module route_tracker is parametrised by N_PORTS and MAX_OUTSTANDING and is instantiated once for loads and once for stores. It holds the counter, cur_port, err_pending and the ready logic.
- The top level does decode, the one-hot strobe generation and the response muxes.

## Test plan
- Same-port pipeline, N_PORTS = 2, port0 = 0x0000_0000–0x7FFF_FFFF: four back-to-back loads to 0x100 give ready high for all four and four port0 strobes. A fifth load sees ready = 0. Port0 valid with data 0xDEAD_BEEF is forwarded in the same cycle.
- Port switch: with a load outstanding to port0, a load to 0x8000_0000 (port1) holds ready = 0 until port0 responds. It is accepted the next cycle and port1 strobes.
- Unmapped: port1 = 0x8000_0000–0x8FFF_FFFF, store to 0xF000_0000 gives no port strobe, and one cycle later stu_done_o = 1 and stu_error_o = 1.
- Simultaneous accept and response at count = 2 leaves count at 2. A stray port1 done while cur_port = 0 is dropped.
- Reset mid-flight with count = 3, followed by a port0 valid after release, gives ldu_valid_o = 0 and ready = 1.
- Overlap: with both windows covering 0x8000_0000, the request goes to port0 only.
